serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single 1-bit full-adder cell across a WIDTH-bit operand pair, one bit per clock, LSB first. It captures the operands and carry-in on a start request and runs a busy/done handshake. It owns the carry flip-flop, the operand shift registers and the bit counter, and publishes a registered sum and carry-out. It sits between a requester (CPU-style sequencer or testbench driver) and the full-adder datapath cell, trading area for latency.

---
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller. Captures two WIDTH-bit operands and a
//   carry-in on an accepted start, then walks a single 1-bit full-adder cell
//   across the operands LSB first, one bit per clock. Publishes a registered
//   sum/carry-out with a busy/done handshake.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted in IDLE or DONE only
//   in_a   in   operand A (WIDTH), captured on the accepting edge
//   in_b   in   operand B (WIDTH), captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout become valid
//   sum    out  registered result (WIDTH), holds the last completed result
//   cout   out  registered carry-out of the MSB, holds with sum
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start; sum/cout hold the last result
//   S_RUN  | one operand bit per clock through the full adder
//   S_DONE | single cycle with done=1; start here chains the next add

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic             carry;
    // Bits remaining after the current one; terminal count is zero.
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sh_s_next;

    assign fa_sum  = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_cout = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sh_s_next = fa_sum;
        end else begin : g_wn
            assign sh_s_next = {fa_sum, sh_s[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= in_a;
                        sh_b  <= in_b;
                        carry <= cin;
                        sh_s  <= '0;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= sh_s_next;
                    carry <= fa_cout;
                    if (cnt == '0) begin
                        sum   <= sh_s_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request yields in_a+in_b+cin
    // exactly WIDTH edges later; busy covers the wait, done marks arrival.
    int             m_left = 0;
    logic [WIDTH:0] m_pend = '0;
    logic [WIDTH:0] m_res = '0;
    logic           m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_res  <= '0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res  <= m_pend;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= (WIDTH+1)'(in_a) + (WIDTH+1)'(in_b) + (WIDTH+1)'(cin);
                m_left <= WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 64'(busy), 64'(m_left != 0));
        chk("model_done", 64'(done), 64'(m_done));
        chk("model_result", 64'({cout, sum}), 64'(m_res));
        if (busy && done) chk("busy_and_done", 64'(1), 64'(0));
    end

    // Waits for done, sampled on falling edges; returns cycles counted from the accepting edge.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic run_add(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input logic [WIDTH-1:0] exp_s, input logic exp_c);
        int cyc;
        @(negedge clk);
        in_a = a; in_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({name, "_busy1"}, 64'(busy), 64'(1));
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(WIDTH + 1));
        chk({name, "_sum"}, 64'(sum), 64'(exp_s));
        chk({name, "_cout"}, 64'(cout), 64'(exp_c));
    endtask

    initial begin
        int cyc;
        int n_done;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_state", 64'({busy, done, cout, sum}), 64'(0));
        end

        run_add("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        repeat (3) @(negedge clk);
        chk("basic_hold", 64'({cout, sum}), 64'h08D);

        run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_add("zero_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Start while busy must be ignored.
        @(negedge clk);
        in_a = 8'h10; in_b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_a = 8'hAA; in_b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("ignore_done_count", 64'(n_done), 64'(1));
        chk("ignore_result", 64'({cout, sum}), 64'h030);

        // Back-to-back with start held high.
        @(negedge clk);
        in_a = 8'h01; in_b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done("b2b_first", cyc);
        chk("b2b_first_result", 64'({cout, sum}), 64'h002);
        in_a = 8'h80; in_b = 8'h80; cin = 1'b1;
        @(negedge clk);
        chk("b2b_busy_again", 64'(busy), 64'(1));
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("b2b_spacing", 64'(cyc), 64'(WIDTH + 1));
        chk("b2b_second_result", 64'({cout, sum}), 64'h101);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        in_a = 8'hF0; in_b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({busy, done, cout, sum}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'(0));
        chk("midrst_result", 64'({cout, sum}), 64'(0));

        run_add("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
